bram_bist: RTL and testbench

Parametrised march-test engine for a single simple-dual-port block RAM, the successor to the hard-coded BRAM script bench. It drives the write and read ports of one `bram` instance and runs a four-element march over every address with a selectable data background. It compares read data through a configurable read-latency pipeline, stops on the first mismatch and reports the failing address and data. It sits between the board top (start button / power-on run, LED status) and the memory under test.

---
 rtl/bram_bist_pkg.sv | 16 +
 rtl/bram_bist_if.sv | 11 +
 rtl/bist_cmp_pipe.sv | 35 +++
 rtl/bram_bist.sv | 138 +++++++++++++
 tb/tb_bram_bist.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_bist_pkg.sv
// bram_bist_pkg: shared state encoding, background modes and pattern function for the BRAM march engine.
package bram_bist_pkg;
   typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DRAIN, S_DONE} state_t;
   localparam logic [1:0] MODE_SOLID = 2'd0;
   localparam logic [1:0] MODE_CHECK = 2'd1;
   localparam logic [1:0] MODE_ADDR = 2'd2;
   localparam int BG_W = 64;
   // Callers keep the low DATA_SZ bits; the reserved mode falls through to solid zeros.
   function automatic logic [BG_W-1:0] background(input logic [BG_W-1:0] addr, input logic [1:0] mode, input int addr_sz);
      logic [BG_W-1:0] p;
      p = '0;
      for (int i = 0; i < BG_W; i++)
         p[i] = mode == MODE_CHECK ? (i[0] ^ addr[0]) : mode == MODE_ADDR ? addr[i % addr_sz] : 1'b0;
      return p;
   endfunction
endpackage

// File: rtl/bram_bist_if.sv
// bram_bist_if: simple-dual-port memory bus between the march engine and the RAM under test.
interface bram_bist_if #(parameter int DATA_SZ = 16, parameter int ADDR_SZ = 8);
   logic wr_en;
   logic [ADDR_SZ-1:0] waddr;
   logic [DATA_SZ-1:0] wdata;
   logic rd_en;
   logic [ADDR_SZ-1:0] raddr;
   logic [DATA_SZ-1:0] rdata;
   modport master (output wr_en, waddr, wdata, rd_en, raddr, input rdata);
   modport slave (input wr_en, waddr, wdata, rd_en, raddr, output rdata);
endinterface

// File: rtl/bist_cmp_pipe.sv
// bist_cmp_pipe: read-latency delay line of {valid, addr, expect} with a compare against returning read data.
module bist_cmp_pipe #(parameter int DATA_SZ = 16, parameter int ADDR_SZ = 8, parameter int LAT = 1) (
   input logic clk,
   input logic rst,
   input logic in_v,
   input logic [ADDR_SZ-1:0] in_addr,
   input logic [DATA_SZ-1:0] in_exp,
   input logic [DATA_SZ-1:0] rdata,
   output logic mismatch,
   output logic drained,
   output logic [ADDR_SZ-1:0] cmp_addr,
   output logic [DATA_SZ-1:0] cmp_exp
);
   localparam logic [LAT-1:0] TOP = LAT'(1) << (LAT - 1);
   logic [LAT-1:0] v;
   logic [ADDR_SZ-1:0] a [LAT];
   logic [DATA_SZ-1:0] e [LAT];
   // A mismatch discards every compare still in flight.
   always_ff @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         v[i] <= v[i-1];
         a[i] <= a[i-1];
         e[i] <= e[i-1];
      end
      v[0] <= in_v;
      a[0] <= in_addr;
      e[0] <= in_exp;
      if (rst || mismatch) v <= '0;
   end
   assign cmp_addr = a[LAT-1];
   assign cmp_exp = e[LAT-1];
   assign mismatch = v[LAT-1] && rdata != e[LAT-1];
   // Only the emerging entry (if any) is left: nothing remains once this cycle's compare retires.
   assign drained = (v & ~TOP) == '0;
endmodule

// File: rtl/bram_bist.sv
// bram_bist: four-element march test over a simple-dual-port BRAM with selectable background,
// stopping on the first mismatch and reporting its address, read data and expected data.
module bram_bist import bram_bist_pkg::*; #(
   parameter int DATA_SZ = 16,
   parameter int ADDR_SZ = 8,
   parameter int RD_LATENCY = 1
) (
   input logic i_clk,
   input logic i_rst,
   input logic i_start,
   input logic [1:0] i_mode,
   bram_bist_if.master mem,
   output logic o_busy,
   output logic o_done,
   output logic o_pass,
   output logic [ADDR_SZ-1:0] o_fail_addr,
   output logic [DATA_SZ-1:0] o_fail_data,
   output logic [DATA_SZ-1:0] o_fail_expect
);
   localparam logic [ADDR_SZ-1:0] LAST = '1;
   state_t state, state_n;
   logic [ADDR_SZ-1:0] addr, addr_n, cmp_addr;
   logic phase, phase_n, wr, rd, start_ok, mismatch, drained, unused_bg;
   logic [1:0] mode;
   logic [BG_W-1:0] bg;
   logic [DATA_SZ-1:0] p, wval, rexp, cmp_exp;
   assign bg = background(BG_W'(addr), mode, ADDR_SZ);
   assign p = bg[DATA_SZ-1:0];
   assign unused_bg = ^bg[BG_W-1:DATA_SZ];
   assign start_ok = i_start && (state == S_IDLE || state == S_DONE);
   assign o_busy = !(state inside {S_IDLE, S_DONE});
   assign o_done = state == S_DONE;
   assign mem.wr_en = wr;
   assign mem.waddr = wr ? addr : '0;
   assign mem.wdata = wr ? wval : '0;
   assign mem.rd_en = rd;
   assign mem.raddr = rd ? addr : '0;
   // M1/M2 spend phase 0 reading and phase 1 writing the same address, so a read never sees its own write.
   always_comb begin
      state_n = state;
      addr_n = addr;
      phase_n = 1'b0;
      wr = 1'b0;
      rd = 1'b0;
      wval = '0;
      rexp = '0;
      case (state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_n = S_M0;
               addr_n = '0;
            end
         end
         S_M0: begin
            wr = 1'b1;
            wval = p;
            addr_n = addr + 1'b1;
            if (addr == LAST) state_n = S_M1;
         end
         S_M1: begin
            rd = !phase;
            wr = phase;
            wval = ~p;
            rexp = p;
            phase_n = !phase;
            if (phase) addr_n = addr + 1'b1;
            if (phase && addr == LAST) begin
               state_n = S_M2;
               addr_n = LAST;
            end
         end
         S_M2: begin
            rd = !phase;
            wr = phase;
            wval = p;
            rexp = ~p;
            phase_n = !phase;
            if (phase) addr_n = addr - 1'b1;
            if (phase && addr == '0) begin
               state_n = S_M3;
               addr_n = '0;
            end
         end
         S_M3: begin
            rd = 1'b1;
            rexp = p;
            addr_n = addr + 1'b1;
            if (addr == LAST) state_n = S_DRAIN;
         end
         S_DRAIN: state_n = drained ? S_DONE : S_DRAIN;
         default: state_n = S_IDLE;
      endcase
      if (mismatch) state_n = S_DONE;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         addr <= '0;
         phase <= 1'b0;
         mode <= MODE_SOLID;
         o_pass <= 1'b0;
         o_fail_addr <= '0;
         o_fail_data <= '0;
         o_fail_expect <= '0;
      end else begin
         state <= state_n;
         addr <= addr_n;
         phase <= phase_n;
         if (start_ok) begin
            mode <= i_mode;
            o_pass <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
            o_fail_expect <= '0;
         end
         if (mismatch) begin
            o_pass <= 1'b0;
            o_fail_addr <= cmp_addr;
            o_fail_data <= mem.rdata;
            o_fail_expect <= cmp_exp;
         end else if (state == S_DRAIN && state_n == S_DONE) begin
            o_pass <= 1'b1;
         end
      end
   end
   bist_cmp_pipe #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .LAT(RD_LATENCY)) u_pipe (
      .clk(i_clk),
      .rst(i_rst),
      .in_v(rd),
      .in_addr(addr),
      .in_exp(rexp),
      .rdata(mem.rdata),
      .mismatch(mismatch),
      .drained(drained),
      .cmp_addr(cmp_addr),
      .cmp_exp(cmp_exp)
   );
endmodule

// File: tb/tb_bram_bist.sv
// tb_bram_bist: march engine against a behavioural RAM with injectable faults; an abstract march
// model fills access/result scoreboards that a negedge monitor drains.
module tb_bram_bist;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int L = 2;
   localparam int D = 1 << AW;
   typedef struct {int cyc; bit wr; int addr; logic [DW-1:0] data;} acc_t;
   typedef struct {bit pass; int addr; logic [DW-1:0] data; logic [DW-1:0] expect_v; int cyc;} res_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic busy, done, pass;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data, fail_expect;
   logic [DW-1:0] ram [D];
   logic [DW-1:0] rq [L];
   acc_t acc_q[$];
   acc_t seq[$];
   res_t res_q[$];
   acc_t got_a;
   res_t got_r;
   int tests = 0, fails = 0, cyc = 0, t0 = 0, runs_seen = 0, fk = 0, fa = 0, fb = 0;
   bit ignore = 1'b1, done_d = 1'b0;

   bram_bist_if #(.DATA_SZ(DW), .ADDR_SZ(AW)) bus ();
   bram_bist #(.DATA_SZ(DW), .ADDR_SZ(AW), .RD_LATENCY(L)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .mem(bus),
      .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_fail_addr(fail_addr), .o_fail_data(fail_data), .o_fail_expect(fail_expect)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // fault kinds: 0 none, 1 bit fb of address fa stuck at 1 on read, 2 address D/2 aliases onto 0
   function automatic int eff(input int a);
      return (fk == 2 && a == D / 2) ? 0 : a;
   endfunction
   function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] d);
      return (fk == 1 && a == fa) ? (d | (DW'(1) << fb)) : d;
   endfunction

   always @(posedge clk) begin
      if (bus.wr_en) ram[eff(int'(bus.waddr))] <= bus.wdata;
      rq[0] <= rd_fault(int'(bus.raddr), ram[eff(int'(bus.raddr))]);
      for (int i = 1; i < L; i++) rq[i] <= rq[i-1];
   end
   assign bus.rdata = rq[L-1];

   function automatic logic [DW-1:0] bg(input int a, input int m);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = ((a >> (i % AW)) & 1) == 1;
      return m == 1 ? ((a % 2) ? {DW/2{2'b01}} : {DW/2{2'b10}}) : m == 2 ? r : '0;
   endfunction

   function automatic void add(input bit wr, input int a, input logic [DW-1:0] d);
      acc_t x;
      x = '{seq.size() + 1, wr, a, d};
      seq.push_back(x);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc - t0, act, req);
      end
   endtask

   // Whole march in order, one access per cycle from cycle 1; reads carry the expected value.
   task automatic predict(input int m);
      logic [DW-1:0] mm [D];
      logic [DW-1:0] got;
      bit failed;
      int fc;
      res_t r;
      failed = 1'b0;
      fc = 0;
      seq.delete();
      for (int a = 0; a < D; a++) add(1'b1, a, bg(a, m));
      for (int a = 0; a < D; a++) begin
         add(1'b0, a, bg(a, m));
         add(1'b1, a, ~bg(a, m));
      end
      for (int a = D - 1; a >= 0; a--) begin
         add(1'b0, a, ~bg(a, m));
         add(1'b1, a, bg(a, m));
      end
      for (int a = 0; a < D; a++) add(1'b0, a, bg(a, m));
      r = '{1'b1, 0, '0, '0, 6 * D + L + 1};
      foreach (seq[k]) begin
         if (failed && seq[k].cyc > fc) break;
         acc_q.push_back(seq[k]);
         if (seq[k].wr) mm[eff(seq[k].addr)] = seq[k].data;
         else if (!failed) begin
            got = rd_fault(seq[k].addr, mm[eff(seq[k].addr)]);
            if (got !== seq[k].data) begin
               failed = 1'b1;
               fc = seq[k].cyc + L;
               r = '{1'b0, seq[k].addr, got, seq[k].data, fc + 1};
            end
         end
      end
      res_q.push_back(r);
   endtask

   always @(negedge clk) begin
      if (!ignore) begin
         if (bus.wr_en || bus.rd_en) begin
            check("rd_wr_exclusive", 64'(bus.wr_en & bus.rd_en), 64'(0));
            if (acc_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_access at cycle %0d: got wr=%0b rd=%0b, expected no access", cyc - t0, bus.wr_en, bus.rd_en);
            end else begin
               got_a = acc_q.pop_front();
               check("access_cycle", 64'(cyc - t0), 64'(got_a.cyc));
               check("access_kind", 64'(bus.wr_en), 64'(got_a.wr));
               check("access_addr", 64'(bus.wr_en ? bus.waddr : bus.raddr), 64'(got_a.addr));
               if (got_a.wr) check("write_data", 64'(bus.wdata), 64'(got_a.data));
            end
         end
         if (done && !done_d) begin
            if (res_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc - t0);
            end else begin
               got_r = res_q.pop_front();
               check("done_cycle", 64'(cyc - t0), 64'(got_r.cyc));
               check("pass", 64'(pass), 64'(got_r.pass));
               check("fail_addr", 64'(fail_addr), 64'(got_r.addr));
               check("fail_data", 64'(fail_data), 64'(got_r.data));
               check("fail_expect", 64'(fail_expect), 64'(got_r.expect_v));
               check("busy_at_done", 64'(busy), 64'(0));
               check("accesses_left", 64'(acc_q.size()), 64'(0));
            end
            runs_seen++;
         end
      end
      done_d = done;
   end

   task automatic reset_dut();
      ignore = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_status", 64'({busy, done, pass, fail_addr, fail_data, fail_expect}), 64'(0));
      check("reset_bus", 64'({bus.wr_en, bus.rd_en, bus.waddr, bus.raddr, bus.wdata}), 64'(0));
      acc_q.delete();
      res_q.delete();
      ignore = 1'b0;
   endtask

   task automatic launch(input int m);
      @(posedge clk);
      #1;
      mode = 2'(m);
      start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      mode = 2'($urandom);
      check("start_clears_results", 64'({done, pass, fail_addr, fail_data, fail_expect}), 64'(0));
      check("busy_cycle1", 64'(busy), 64'(1));
   endtask

   task automatic run(input int m, input int kind, input int a, input int b, input bit pulse);
      int n;
      fk = kind;
      fa = a;
      fb = b;
      predict(m);
      n = runs_seen;
      launch(m);
      if (pulse) begin
         repeat (3 * D + 4) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      for (int i = 0; i < 400 && runs_seen == n; i++) @(posedge clk);
      if (runs_seen == n) begin
         tests++;
         fails++;
         $display("FAIL run_timeout mode %0d: got no done within 400 cycles, expected done", m);
         reset_dut();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      reset_dut();
      run(0, 0, 0, 0, 1'b0);
      run(1, 1, 5, 3, 1'b0);
      run(2, 2, 0, 0, 1'b0);
      run(3, 0, 0, 0, 1'b0);
      run(2, 0, 0, 0, 1'b1);
      fk = 0;
      predict(1);
      launch(1);
      repeat (D + 4) @(posedge clk);
      #1;
      reset_dut();
      repeat (6) @(posedge clk);
      #1;
      check("idle_after_reset", 64'({busy, done}), 64'(0));
      run(0, 0, 0, 0, 1'b0);
      repeat (10) run(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, D - 1)), int'($urandom_range(0, DW - 1)), 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
